// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Multi-read-port register file with a per-entry busy scoreboard and a
//   sequential clear engine.
//
// Ports:
//   clk              clock, rising edge
//   reset_n          asynchronous active-low reset (clears file, busy, FSM)
//   write_enable     write value_write to address_write (also clears busy)
//   address_write    write address
//   value_write      write data
//   reserve_enable   set busy bit of reserve_address
//   reserve_address  register being reserved
//   address_read     packed read addresses, port i = [i*ADDR_BITS +: ADDR_BITS]
//   value_read       packed read data, port i = [i*WIDTH +: WIDTH]
//   busy_read        busy status of each read port's address
//   clear_start      start a sequential clear, one entry per cycle
//   clear_busy       high while the clear engine runs
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int ADDR_BITS  = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            write_enable,
    input  logic [ADDR_BITS-1:0]            address_write,
    input  logic [WIDTH-1:0]                value_write,
    input  logic                            reserve_enable,
    input  logic [ADDR_BITS-1:0]            reserve_address,
    input  logic [READ_PORTS*ADDR_BITS-1:0] address_read,
    output logic [READ_PORTS*WIDTH-1:0]     value_read,
    output logic [READ_PORTS-1:0]           busy_read,
    input  logic                            clear_start,
    output logic                            clear_busy
);

    localparam int DEPTH = 2**ADDR_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ADDR_BITS-1:0]   r_count;
    logic                   r_clear_busy;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [DEPTH-1:0]       r_busy;

    logic                   w_idle;
    logic                   w_wr_ok;
    logic                   w_rs_ok;

    assign w_idle  = (r_state == ST_IDLE);
    // Accepted write/reserve: only while idle, and never to the hardwired zero register.
    assign w_wr_ok = write_enable && w_idle &&
                     !((ZERO_REG != 0) && (address_write == '0));
    assign w_rs_ok = reserve_enable && w_idle &&
                     !((ZERO_REG != 0) && (reserve_address == '0));

    // Clear engine. clear_busy is registered alongside the state so it
    // tracks (state == CLEAR) exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state      <= ST_CLEAR;
                        r_count      <= '0;
                        r_clear_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Counter wraps back to 0 after the last entry.
                    r_count <= r_count + 1'b1;
                    if (r_count == ADDR_BITS'(DEPTH - 1)) begin
                        r_state      <= ST_IDLE;
                        r_clear_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_clear_busy <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = r_clear_busy;

    // Storage and scoreboard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_count]  <= '0;
            r_busy[r_count] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[address_write]  <= value_write;
                r_busy[address_write] <= 1'b0;
            end
            // Placed after the write so a same-address reserve wins:
            // a new producer has been issued for that register.
            if (w_rs_ok) begin
                r_busy[reserve_address] <= 1'b1;
            end
        end
    end

    // Combinational read ports with optional write forwarding.
    for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read
        logic [ADDR_BITS-1:0] w_addr;
        logic                 w_zero;
        logic                 w_hit;

        assign w_addr = address_read[gi*ADDR_BITS +: ADDR_BITS];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
        // w_wr_ok already excludes CLEAR and the zero register.
        assign w_hit  = (BYPASS != 0) && w_wr_ok && (address_write == w_addr);

        assign value_read[gi*WIDTH +: WIDTH] = w_zero ? '0 :
                                               (w_hit ? value_write : r_mem[w_addr]);
        assign busy_read[gi] = !w_zero && !w_hit && r_busy[w_addr];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Three instances share one stimulus stream:
//     A: default configuration (bypass on)
//     B: same geometry, bypass off
//     C: WIDTH=16, ADDR_BITS=3, READ_PORTS=3 (takes low address/data bits)
//   A behavioural model (arrays + clear countdown) predicts every read port,
//   busy bit and clear_busy each cycle.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we, re, cs;
    logic [4:0]  wa, ra;
    logic [31:0] wv;
    logic [9:0]  ar;
    logic [2:0]  ar2;
    logic [8:0]  ar_c;

    logic [63:0] vr_a, vr_b;
    logic [1:0]  br_a, br_b;
    logic        cb_a, cb_b;
    logic [47:0] vr_c;
    logic [2:0]  br_c;
    logic        cb_c;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] ma [32];
    logic [31:0] mba;
    int          clra;
    logic [15:0] mc [8];
    logic [7:0]  mbc;
    int          clrc;

    assign ar_c = {ar2, ar[7:5], ar[2:0]};

    always #5 clk = ~clk;

    regfile_scoreboard u_a (
        .clk(clk), .reset_n(reset_n),
        .write_enable(we), .address_write(wa), .value_write(wv),
        .reserve_enable(re), .reserve_address(ra),
        .address_read(ar), .value_read(vr_a), .busy_read(br_a),
        .clear_start(cs), .clear_busy(cb_a)
    );

    regfile_scoreboard #(.BYPASS(0)) u_b (
        .clk(clk), .reset_n(reset_n),
        .write_enable(we), .address_write(wa), .value_write(wv),
        .reserve_enable(re), .reserve_address(ra),
        .address_read(ar), .value_read(vr_b), .busy_read(br_b),
        .clear_start(cs), .clear_busy(cb_b)
    );

    regfile_scoreboard #(.WIDTH(16), .ADDR_BITS(3), .READ_PORTS(3)) u_c (
        .clk(clk), .reset_n(reset_n),
        .write_enable(we), .address_write(wa[2:0]), .value_write(wv[15:0]),
        .reserve_enable(re), .reserve_address(ra[2:0]),
        .address_read(ar_c), .value_read(vr_c), .busy_read(br_c),
        .clear_start(cs), .clear_busy(cb_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ma[i] = '0;
        for (int i = 0; i < 8; i++) mc[i] = '0;
        mba  = '0;
        mbc  = '0;
        clra = 0;
        clrc = 0;
    endtask

    // Apply the inputs present at a clock edge to the model.
    task automatic model_update();
        if (clra > 0) begin
            ma[32-clra]  = '0;
            mba[32-clra] = 1'b0;
            clra--;
        end else begin
            if (we && wa != 0) begin ma[wa] = wv; mba[wa] = 1'b0; end
            if (re && ra != 0) mba[ra] = 1'b1;
            if (cs) clra = 32;
        end
        if (clrc > 0) begin
            mc[8-clrc]  = '0;
            mbc[8-clrc] = 1'b0;
            clrc--;
        end else begin
            if (we && wa[2:0] != 0) begin mc[wa[2:0]] = wv[15:0]; mbc[wa[2:0]] = 1'b0; end
            if (re && ra[2:0] != 0) mbc[ra[2:0]] = 1'b1;
            if (cs) clrc = 8;
        end
    endtask

    task automatic check_reads();
        logic [4:0]  a;
        logic [2:0]  c;
        logic        hit;
        logic [31:0] ev;
        logic        eb;
        logic [15:0] ev16;
        for (int p = 0; p < 2; p++) begin
            a   = ar[p*5 +: 5];
            hit = (clra == 0) && we && (wa == a) && (a != 0);
            ev  = (a == 0) ? 32'd0 : (hit ? wv : ma[a]);
            eb  = (a == 0) ? 1'b0 : (hit ? 1'b0 : mba[a]);
            chk($sformatf("A_val_p%0d_x%0d", p, a), 64'(vr_a[p*32 +: 32]), 64'(ev));
            chk($sformatf("A_busy_p%0d_x%0d", p, a), 64'(br_a[p]), 64'(eb));
            ev  = (a == 0) ? 32'd0 : ma[a];
            eb  = (a == 0) ? 1'b0 : mba[a];
            chk($sformatf("B_val_p%0d_x%0d", p, a), 64'(vr_b[p*32 +: 32]), 64'(ev));
            chk($sformatf("B_busy_p%0d_x%0d", p, a), 64'(br_b[p]), 64'(eb));
        end
        for (int p = 0; p < 3; p++) begin
            c    = ar_c[p*3 +: 3];
            hit  = (clrc == 0) && we && (wa[2:0] == c) && (c != 0);
            ev16 = (c == 0) ? 16'd0 : (hit ? wv[15:0] : mc[c]);
            eb   = (c == 0) ? 1'b0 : (hit ? 1'b0 : mbc[c]);
            chk($sformatf("C_val_p%0d_x%0d", p, c), 64'(vr_c[p*16 +: 16]), 64'(ev16));
            chk($sformatf("C_busy_p%0d_x%0d", p, c), 64'(br_c[p]), 64'(eb));
        end
        chk("A_clear_busy", 64'(cb_a), 64'(clra > 0));
        chk("B_clear_busy", 64'(cb_b), 64'(clra > 0));
        chk("C_clear_busy", 64'(cb_c), 64'(clrc > 0));
    endtask

    // Inputs are already set; check combinational outputs mid-cycle, then
    // clock and advance the model. Returns 1 time unit after the edge.
    task automatic step();
        @(negedge clk);
        check_reads();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; re = 1'b0; cs = 1'b0;
    endtask

    // Every entry written with nonzero data and reserved in the same cycle.
    task automatic fill_all();
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wv = $urandom | 32'h0001_0001;
            re = 1'b1; ra = 5'(i);
            ar = $urandom; ar2 = 3'($urandom);
            step();
        end
        idle_inputs();
    endtask

    task automatic scan_all();
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            ar  = {5'(2*i+1), 5'(2*i)};
            ar2 = 3'(i);
            step();
        end
    endtask

    task automatic mid_reset(input int n);
        idle_inputs();
        cs = 1'b1;
        step();
        cs = 1'b0;
        repeat (n) step();
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            ar = $urandom; ar2 = 3'($urandom);
            #1;
            check_reads();
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b1; wa = 5'd9; wv = 32'h1;
        step();
        idle_inputs();
        ar = {5'd9, 5'd9}; ar2 = 3'd1;
        step();
        chk("rst_x9_A", 64'(vr_a[31:0]), 64'h1);
        chk("rst_x1_C", 64'(vr_c[15:0]), 64'h1);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        wa = '0; ra = '0; wv = '0; ar = '0; ar2 = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            ar = $urandom; ar2 = 3'($urandom);
            #3;
            check_reads();
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x5, read on both ports
        we = 1'b1; wa = 5'd5; wv = 32'hDEADBEEF; ar = {5'd5, 5'd5}; ar2 = 3'd0;
        step();
        idle_inputs();
        step();
        chk("t1_p0", 64'(vr_a[31:0]), 64'hDEADBEEF);
        chk("t1_p1", 64'(vr_b[63:32]), 64'hDEADBEEF);

        // Zero register: write and reserve x0
        we = 1'b1; wa = 5'd0; wv = 32'h12345678; re = 1'b1; ra = 5'd0;
        ar = {5'd0, 5'd0};
        step();
        idle_inputs();
        step();
        chk("t2_x0_val", vr_a, 64'h0);
        chk("t2_x0_busy", 64'(br_a), 64'h0);

        // Bypass on x7
        we = 1'b1; wa = 5'd7; wv = 32'hA5A5A5A5; ar = {5'd7, 5'd7}; ar2 = 3'd7;
        #2;
        chk("t3_bypass_A", vr_a, {2{32'hA5A5A5A5}});
        chk("t3_nobypass_B", vr_b, 64'h0);
        step();
        idle_inputs();
        step();
        chk("t3_next_B", vr_b, {2{32'hA5A5A5A5}});

        // Scoreboard on x3
        re = 1'b1; ra = 5'd3; ar = {5'd3, 5'd3}; ar2 = 3'd3;
        step();
        idle_inputs();
        step();
        chk("t4_reserved", 64'(br_a), 64'h3);
        we = 1'b1; wa = 5'd3; wv = 32'h33;
        step();
        idle_inputs();
        step();
        chk("t4_written", 64'(br_a), 64'h0);
        we = 1'b1; wa = 5'd3; wv = 32'h4444; re = 1'b1; ra = 5'd3;
        step();
        idle_inputs();
        step();
        chk("t4_both_busy", 64'(br_b), 64'h3);
        chk("t4_both_val", 64'(vr_b[31:0]), 64'h4444);

        // Randomised traffic, occasional clears
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom); wa = 5'($urandom); wv = $urandom;
            re = 1'($urandom); ra = 5'($urandom);
            cs = ($urandom_range(0, 63) == 0);
            ar = $urandom; ar2 = 3'($urandom);
            step();
        end
        idle_inputs();
        repeat (34) step();

        // Full clear with a write attempted mid-clear
        fill_all();
        cs = 1'b1;
        step();
        cs = 1'b0;
        for (int i = 0; i < 34; i++) begin
            we = (i == 12); wa = 5'd31; wv = 32'hCAFEF00D;
            re = (i == 14); ra = 5'd30;
            ar = $urandom; ar2 = 3'($urandom);
            step();
        end
        idle_inputs();
        scan_all();

        // Reset during clear
        fill_all();
        mid_reset(10);
        fill_all();
        mid_reset(4);
        scan_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-read-port register file for the CPU datapath: configurable data width, depth and read-port count, an optional hardwired zero register, and optional write-to-read bypass. A per-register busy scoreboard lets issue logic reserve a destination and detect pending sources. A sequential clear engine zeroes the whole file on request, one entry per cycle.

Parameters:
WIDTH, 32, data bits per register
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS entries
READ_PORTS, 2, number of independent read ports (>=1)
ZERO_REG, 1, 1 = entry 0 always reads 0 and is never written or reserved
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
write_enable  input  1  write value_write to address_write at the clock edge
address_write  input  ADDR_BITS  write address
value_write  input  WIDTH  write data
reserve_enable  input  1  set busy bit of reserve_address
reserve_address  input  ADDR_BITS  register being reserved
address_read  input  READ_PORTS*ADDR_BITS  packed read addresses; port i = bits [i*ADDR_BITS +: ADDR_BITS]
value_read  output  READ_PORTS*WIDTH  packed read data, port i = bits [i*WIDTH +: WIDTH]
busy_read  output  READ_PORTS  busy status of each read port's address
clear_start  input  1  start a sequential clear of all entries
clear_busy  output  1  high while the clear engine runs

Behaviour:
- Reset (reset_n low, asynchronous): all entries = 0, all busy bits = 0, FSM = IDLE, counter = 0, clear_busy = 0. Hence value_read = 0 and busy_read = 0 during reset.
- Reads are combinational: value_read[i] = mem[address_read[i]]. With ZERO_REG = 1, address 0 always reads 0 and busy 0.
- Write: at the clock edge, if write_enable is high and the FSM is IDLE, mem[address_write] <= value_write and busy[address_write] <= 0. Writes to address 0 with ZERO_REG = 1 are dropped.
- Reserve: at the clock edge, if reserve_enable is high and the FSM is IDLE, busy[reserve_address] <= 1. Reserves to address 0 with ZERO_REG = 1 are dropped.
- Write and reserve to the same address in one cycle:
  - the data is written;
  - busy ends at 1 (reserve wins, i.e. a new producer is issued).
- Bypass (BYPASS = 1, FSM IDLE, write_enable high, address_write == address_read[i], and not zero-reg address 0):
  - value_read[i] = value_write;
  - busy_read[i] = 0.
  - This applies independently per port, and several ports may hit at once.
- No bypass (BYPASS = 0): the new value is visible the cycle after the write. busy_read[i] = busy[address_read[i]].
- Reserve has no same-cycle effect on busy_read; it is visible the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clear_start high -> CLEAR, counter <= 0.
  - CLEAR: each cycle, mem[counter] <= 0 and busy[counter] <= 0, then counter++.
  - At counter == DEPTH-1 the entry is cleared and the FSM returns to IDLE.
  - clear_busy = (state == CLEAR). It is high for exactly DEPTH cycles, starting the cycle after clear_start.
- During CLEAR:
  - write_enable, reserve_enable and clear_start are ignored (dropped, not queued);
  - bypass is disabled;
  - reads return current array contents, so already-cleared entries read 0.
- Counter wraps naturally at DEPTH; no other terminal condition.
- reset_n asserted mid-clear aborts immediately to the reset state.
- Out-of-range addresses cannot occur (DEPTH = 2**ADDR_BITS).

Test Plan:
1. Reset, then write 0xDEADBEEF to x5 and read it back on both ports -> both ports read 0xDEADBEEF the cycle after the write; x0 reads 0.
2. ZERO_REG: write 0x12345678 to x0 and reserve x0 -> x0 reads 0 and busy_read = 0 on every port, always.
3. Bypass: BYPASS = 1, write 0xA5A5A5A5 to x7 while port0 and port1 both read x7 in the same cycle -> both ports show 0xA5A5A5A5 and busy_read = 0 in that cycle. With BYPASS = 0 -> the old value is shown that cycle and the new value the next cycle.
4. Scoreboard: reserve x3 -> busy_read = 1 from the next cycle. Write x3 -> busy = 0. Write and reserve x3 in the same cycle -> data updated and busy stays 1.
5. Clear: fill all 32 entries with nonzero values, mark all busy, pulse clear_start -> clear_busy high for 32 cycles; a write issued mid-clear is dropped; afterwards every entry reads 0 with busy 0.
6. Reset mid-clear: assert reset_n low on clear cycle 10 -> clear_busy = 0 and all entries 0 immediately. After release, a write to x9 of 0x1 succeeds. Repeat with WIDTH = 16, ADDR_BITS = 3, READ_PORTS = 3.
